insn_sequencer: RTL and testbench

INSN_SEQUENCER -- requirements
Module: insn_sequencer

---
 rtl/insn_seq_pkg.sv | 14 +
 rtl/insn_fifo.sv | 50 +++++
 rtl/insn_sequencer.sv | 107 ++++++++++
 tb/tb_insn_sequencer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/insn_seq_pkg.sv
// rtl/insn_seq_pkg.sv - shared widths, defaults and FSM state type for the instruction sequencer
package insn_seq_pkg;
  localparam int INSN_W               = 32;
  localparam int REG_IDX_W            = 5;
  localparam int DEFAULT_DEPTH        = 8;
  localparam int DEFAULT_DRAIN_CYCLES = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_READ  = 2'd3
  } state_e;
endpackage

// File: rtl/insn_fifo.sv
// rtl/insn_fifo.sv - instruction FIFO with extra-MSB wrap pointers, head shown combinationally
module insn_fifo
  import insn_seq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_i,
  input  logic [INSN_W-1:0] data_i,
  input  logic              pop_i,
  output logic [INSN_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              last_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]       occ;
  logic [INSN_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign occ     = wr_ptr_q - rd_ptr_q;
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign last_o  = (occ == (AW+1)'(1));
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Full is judged on registered occupancy, so a same-cycle pop never frees a slot early.
  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/insn_sequencer.sv
// rtl/insn_sequencer.sv - feeds queued host instructions to the processor, drains, and services register readback
module insn_sequencer
  import insn_seq_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [INSN_W-1:0]    host_insn,
  input  logic                 host_valid,
  output logic                 host_ready,
  input  logic                 rd_req,
  input  logic [REG_IDX_W-1:0] rd_reg,
  output logic                 rd_ack,
  output logic [INSN_W-1:0]    rd_data,
  output logic [INSN_W-1:0]    insn_to_use,
  output logic                 active_insn,
  output logic [REG_IDX_W-1:0] reg_to_read,
  output logic                 reading,
  input  logic [INSN_W-1:0]    reg_val,
  output logic                 busy
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [INSN_W-1:0] rd_data_q, rd_data_d;
  logic              rd_ack_q, rd_ack_d;

  logic              fifo_full, fifo_empty, fifo_last, fifo_pop, push_acc;
  logic [INSN_W-1:0] fifo_head;

  assign host_ready = !fifo_full;
  assign push_acc   = host_valid && !fifo_full;

  insn_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (host_valid),
    .data_i  (host_insn),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .last_o  (fifo_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      rd_ack_q  <= rd_ack_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_data_d   = rd_data_q;
    rd_ack_d    = 1'b0;
    fifo_pop    = 1'b0;
    active_insn = 1'b0;
    insn_to_use = '0;
    reading     = 1'b0;
    reg_to_read = '0;
    case (state_q)
      ST_IDLE: begin
        // The request is still held high during the ack cycle; skip it so one request reads once.
        if (rd_req && !rd_ack_q) state_d = ST_READ;
        else if (!fifo_empty)    state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        active_insn = 1'b1;
        insn_to_use = fifo_head;
        fifo_pop    = 1'b1;
        if (fifo_last && !push_acc) begin
          state_d = ST_DRAIN;
          cnt_d   = CW'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        if (!fifo_empty)        state_d = ST_ISSUE;
        else if (cnt_q == '0)   state_d = ST_IDLE;
        else                    cnt_d   = cnt_q - CW'(1);
      end
      ST_READ: begin
        reading     = 1'b1;
        reg_to_read = rd_reg;
        rd_data_d   = reg_val;
        rd_ack_d    = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_ack  = rd_ack_q;
  assign rd_data = rd_data_q;
  assign busy    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_insn_sequencer.sv
// tb/tb_insn_sequencer.sv - directed checks of issue, drain, readback, full FIFO and reset behaviour
module tb_insn_sequencer;
  logic        clock, reset;
  logic [31:0] host_insn, reg_val, rd_data, insn_to_use;
  logic        host_valid, host_ready, rd_req, rd_ack, active_insn, reading, busy;
  logic [4:0]  rd_reg, reg_to_read;

  // Second instance with a two-entry FIFO: the only depth at which the queue can actually fill.
  logic [31:0] f_insn, f_rd_data, f_insn_to_use;
  logic        f_valid, f_ready, f_rd_ack, f_active, f_reading, f_busy;
  logic [4:0]  f_reg_to_read;
  logic        f_rd_req;
  logic [4:0]  f_rd_reg;
  logic [31:0] f_reg_val;

  int total = 0;
  int bad   = 0;

  insn_sequencer dut (
    .clock(clock), .reset(reset), .host_insn(host_insn), .host_valid(host_valid),
    .host_ready(host_ready), .rd_req(rd_req), .rd_reg(rd_reg), .rd_ack(rd_ack),
    .rd_data(rd_data), .insn_to_use(insn_to_use), .active_insn(active_insn),
    .reg_to_read(reg_to_read), .reading(reading), .reg_val(reg_val), .busy(busy)
  );

  insn_sequencer #(.DEPTH(2), .DRAIN_CYCLES(5)) dut_small (
    .clock(clock), .reset(reset), .host_insn(f_insn), .host_valid(f_valid),
    .host_ready(f_ready), .rd_req(f_rd_req), .rd_reg(f_rd_reg), .rd_ack(f_rd_ack),
    .rd_data(f_rd_data), .insn_to_use(f_insn_to_use), .active_insn(f_active),
    .reg_to_read(f_reg_to_read), .reading(f_reading), .reg_val(f_reg_val), .busy(f_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; host_insn = '0; host_valid = 0; rd_req = 0; rd_reg = '0; reg_val = '0;
    f_insn = '0; f_valid = 0; f_rd_req = 0; f_rd_reg = '0; f_reg_val = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", host_ready, 1);
    chk("rst_active", active_insn, 0);
    chk("rst_insn", insn_to_use, 0);
    chk("rst_reading", reading, 0);
    chk("rst_regidx", reg_to_read, 0);
    chk("rst_ack", rd_ack, 0);
    chk("rst_rdata", rd_data, 0);
    reset = 1'b0;

    // three-word burst
    host_valid = 1; host_insn = 32'h00500093;
    tick(); chk("b_idle_busy", busy, 0); chk("b_idle_act", active_insn, 0);
    host_insn = 32'h00A00113;
    tick(); chk("b_act0", active_insn, 1); chk("b_insn0", insn_to_use, 32'h00500093);
    host_insn = 32'h002081B3;
    tick(); chk("b_act1", active_insn, 1); chk("b_insn1", insn_to_use, 32'h00A00113);
    host_valid = 0;
    tick(); chk("b_act2", active_insn, 1); chk("b_insn2", insn_to_use, 32'h002081B3);
    for (int i = 0; i < 5; i++) begin
      tick(); chk("b_drain_act", active_insn, 0); chk("b_drain_insn", insn_to_use, 0);
      chk("b_drain_busy", busy, 1);
    end
    tick(); chk("b_idle_after", busy, 0);

    // readback from IDLE
    rd_req = 1; rd_reg = 5'd3; reg_val = 32'h0000000F;
    tick(); chk("r_reading", reading, 1); chk("r_idx", reg_to_read, 3); chk("r_busy", busy, 1);
    chk("r_noack", rd_ack, 0);
    tick(); chk("r_ack", rd_ack, 1); chk("r_data", rd_data, 32'h0000000F); chk("r_ack_rd", reading, 0);
    rd_req = 0; reg_val = 32'h12345678;
    tick(); chk("r_ack_pulse", rd_ack, 0); chk("r_hold", rd_data, 32'h0000000F);
    chk("r_no_double", reading, 0); chk("r_idle", busy, 0);

    // readback requested mid-burst waits for drain
    host_valid = 1; host_insn = 32'h11111111;
    tick(); host_insn = 32'h22222222;
    tick(); host_insn = 32'h33333333;
    tick(); host_valid = 0; rd_req = 1; rd_reg = 5'd7; reg_val = 32'hCAFEBABE;
    chk("w_issue2", insn_to_use, 32'h22222222); chk("w_rd0", reading, 0);
    tick(); chk("w_issue3", insn_to_use, 32'h33333333); chk("w_rd1", reading, 0);
    for (int i = 0; i < 5; i++) begin
      tick(); chk("w_drain_rd", reading, 0); chk("w_drain_busy", busy, 1);
    end
    tick(); chk("w_idle_rd", reading, 0); chk("w_idle_busy", busy, 0);
    tick(); chk("w_reading", reading, 1); chk("w_idx", reg_to_read, 7);
    tick(); chk("w_ack", rd_ack, 1); chk("w_data", rd_data, 32'hCAFEBABE);
    rd_req = 0;
    tick(); chk("w_ack_end", rd_ack, 0);

    // push lands so that drain count 2 sees a non-empty FIFO
    host_valid = 1; host_insn = 32'hAAAA0001;
    tick(); host_valid = 0;
    tick(); chk("d_issue_x", insn_to_use, 32'hAAAA0001);
    tick(); chk("d_cnt4", active_insn, 0);
    tick(); host_valid = 1; host_insn = 32'hBBBB0002;
    tick(); host_valid = 0; chk("d_cnt2_act", active_insn, 0); chk("d_cnt2_busy", busy, 1);
    tick(); chk("d_reissue_act", active_insn, 1); chk("d_reissue", insn_to_use, 32'hBBBB0002);
    for (int i = 0; i < 5; i++) begin
      tick(); chk("d_redrain_act", active_insn, 0); chk("d_redrain_busy", busy, 1);
    end
    tick(); chk("d_idle", busy, 0);

    // full FIFO on the two-entry instance
    f_valid = 1; f_insn = 32'hF0000000;
    tick(); chk("f_ready1", f_ready, 1); f_insn = 32'hF0000001;
    tick(); chk("f_full", f_ready, 0); chk("f_issue0", f_insn_to_use, 32'hF0000000);
    f_insn = 32'hF0000002;
    tick(); f_valid = 0; chk("f_ready_again", f_ready, 1); chk("f_issue1", f_insn_to_use, 32'hF0000001);
    for (int i = 0; i < 5; i++) begin
      tick(); chk("f_no_third", f_active, 0); chk("f_drain_busy", f_busy, 1);
    end
    tick(); chk("f_idle", f_busy, 0);

    // reset during ISSUE with a pending read
    host_valid = 1; host_insn = 32'h0C000000;
    tick(); host_insn = 32'h0C000001;
    tick(); host_insn = 32'h0C000002;
    tick(); host_insn = 32'h0C000003; rd_req = 1; rd_reg = 5'd9;
    tick(); host_valid = 0; chk("x_pre_act", active_insn, 1);
    reset = 1; rd_req = 0;
    #1;
    chk("x_act", active_insn, 0); chk("x_insn", insn_to_use, 0);
    chk("x_busy", busy, 0); chk("x_ready", host_ready, 1);
    tick(); reset = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); chk("x_post_act", active_insn, 0); chk("x_post_ack", rd_ack, 0);
      chk("x_post_busy", busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
